bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Clock and reset shall be as decided: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 ar  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 hundreds  input  4  BCD hundreds digit.
REQ-006 tens  input  4  BCD tens digit.
REQ-007 ones  input  4  BCD ones digit.
REQ-008 sign  input  1  1 = negative operand.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 binary  output  11  two's-complement result, range -999..+999; held until the next accepted start.
REQ-012 err  output  1  invalid-digit flag; valid with done, held until the next accepted start.

Function
REQ-013 FSM states shall be IDLE, SHIFT, NEG and DONE, and no others.
REQ-014 IDLE with start=1 shall latch digits and sign, clear err, clear the 4-bit shift counter, and go to SHIFT; busy shall rise the next cycle.
REQ-015 SHIFT shall use reverse double-dabble on the {BCD[11:0], BIN[9:0]} register:
- Each cycle, shift the register right 1.
- Then subtract 3 from each BCD digit that is >= 8.
- Run exactly 10 cycles, then go to NEG.
REQ-016 NEG shall set binary = sign ? -magnitude : magnitude, sign-extended to 11 bits, then go to DONE.
REQ-017 DONE shall assert done for exactly one cycle, deassert busy, and return unconditionally to IDLE.
REQ-018 Latency shall be fixed: done high 12 cycles after the cycle in which start was sampled.
REQ-019 Start shall be ignored in SHIFT, NEG and DONE; there is no queuing, and latched operands shall not change.
REQ-020 Input digit changes after acceptance shall not affect the result.
REQ-021 Sign=1 with magnitude 0 shall yield binary=0 (no negative zero).
REQ-022 busy and done shall never both be high in the same cycle.

Reset
REQ-023 Assertion of ar shall force, immediately and regardless of clk:
- state = IDLE
- busy = 0, done = 0, err = 0
- binary = 0
- counter and shift register = 0
REQ-024 Reset mid-conversion shall abort the conversion with no done pulse; the first start after deassertion shall behave as a fresh conversion.

Configuration
REQ-025 Macro BCD2BIN_DIGIT_CHECK_EN, when defined, shall check latched digits in IDLE on start.
REQ-026 With the macro defined, any digit > 9 shall skip SHIFT and NEG:
- go directly to DONE
- err = 1, binary = 0
- done high 2 cycles after start was sampled
REQ-027 Without the macro, err shall be constant 0 and all digits shall run the normal algorithm; results for digits > 9 are defined only by that algorithm.

Structure
REQ-028 Shared package pr4_pkg shall hold:
- state enum
- NUM_DIGITS = 3
- BIN_W = 11
- SHIFT_CNT = 10
- BCD_ADJ_THRESH = 8
REQ-029 One sub-module, bcd_digit_adj, shall implement the combinational per-digit rule: if >= 8, subtract 3.
REQ-030 The block shall instantiate three bcd_digit_adj copies.

Verification
REQ-031 Digits 9,9,9, sign 0, start pulse -> done at cycle +12, binary = 11'h3E7, err = 0.
REQ-032 Digits 1,2,7, sign 1 -> binary = 11'h781 (-127); digits 0,0,0, sign 1 -> binary = 0.
REQ-033 Start re-pulsed at cycles +3 and +11 with different digits -> single done, result of the original operands only.
REQ-034 With BCD2BIN_DIGIT_CHECK_EN, digits 0,A,5 -> done at +2, err = 1, binary = 0; next valid 0,0,5 -> err = 0, binary = 5.
REQ-035 ar asserted at cycle +6 of a conversion -> busy/done/binary = 0 immediately, no done pulse; restart with 4,5,6 -> binary = 456 at +12.

Source files
------------

// File: rtl/pr4_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the FSM state type, datapath widths and the operand payload struct.
package pr4_pkg;

   localparam int unsigned NUM_DIGITS     = 3;
   localparam int unsigned DIGIT_W        = 4;
   localparam int unsigned BIN_W          = 11;
   localparam int unsigned MAG_W          = BIN_W - 1;
   localparam int unsigned SR_W           = NUM_DIGITS * DIGIT_W + MAG_W;
   localparam int unsigned SHIFT_CNT      = 10;
   localparam int unsigned CNT_W          = 4;
   localparam int unsigned BCD_ADJ_THRESH = 8;
   localparam int unsigned BCD_ADJ_SUB    = 3;
   localparam int unsigned BCD_MAX        = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      NEG   = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Operand as presented on the input pins.
   typedef struct packed {
      logic               sign;
      logic [DIGIT_W-1:0] hundreds;
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } bcd_operand_t;

   // True when a nibble is not a legal BCD digit.
   function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
      return d > DIGIT_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: digits >= 8 lose 3.
// Ports:
//   digit_i - BCD digit after the right shift
//   adj_c   - corrected digit (combinational)
module bcd_digit_adj
   import pr4_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] adj_c
);

   always_comb begin
      adj_c = digit_i;
      if (digit_i >= DIGIT_W'(BCD_ADJ_THRESH)) begin
         adj_c = digit_i - DIGIT_W'(BCD_ADJ_SUB);
      end
   end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit signed BCD to 11-bit two's-complement converter.
// Reverse double-dabble over a {BCD, BIN} shift register, one bit per cycle.
// Optional build macro: BCD2BIN_DIGIT_CHECK_EN (reject digits > 9 with err).
// Ports:
//   clk      - clock, rising edge
//   ar       - asynchronous active-low reset
//   start    - conversion request, honoured only when idle
//   hundreds, tens, ones, sign - operand
//   busy     - conversion in progress
//   done     - one-cycle completion pulse
//   binary   - signed result, held until the next conversion writes it
//   err      - invalid-digit flag, valid with done
module bcd2bin_seq
   import pr4_pkg::*;
(
   input  logic               clk,
   input  logic               ar,
   input  logic               start,
   input  logic [DIGIT_W-1:0] hundreds,
   input  logic [DIGIT_W-1:0] tens,
   input  logic [DIGIT_W-1:0] ones,
   input  logic               sign,
   output logic               busy,
   output logic               done,
   output logic [BIN_W-1:0]   binary,
   output logic               err
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [SR_W-1:0]    sr_q,    sr_d;
   logic               sign_q,  sign_d;
   logic               bad_q,   bad_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;
   logic [BIN_W-1:0]   bin_q,   bin_d;

   bcd_operand_t       op_c;
   logic               inv_c;
   logic [SR_W-1:0]    sr_shr_c;
   logic [SR_W-1:0]    sr_adj_c;
   logic [BIN_W-1:0]   mag_ext_c;

   assign op_c = '{sign: sign, hundreds: hundreds, tens: tens, ones: ones};

`ifdef BCD2BIN_DIGIT_CHECK_EN
   assign inv_c = digit_invalid(op_c.hundreds) | digit_invalid(op_c.tens) |
                  digit_invalid(op_c.ones);
`else
   assign inv_c = 1'b0;
`endif

   // One shift step: shift right, then correct every BCD digit.
   assign sr_shr_c = sr_q >> 1;
   assign sr_adj_c[MAG_W-1:0] = sr_shr_c[MAG_W-1:0];

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (sr_shr_c[MAG_W + g*DIGIT_W +: DIGIT_W]),
         .adj_c   (sr_adj_c[MAG_W + g*DIGIT_W +: DIGIT_W])
      );
   end

   assign mag_ext_c = {1'b0, sr_q[MAG_W-1:0]};

   // State and datapath registers.
   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         sign_q  <= 1'b0;
         bad_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         sign_q  <= sign_d;
         bad_q   <= bad_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         bin_q   <= bin_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      sign_d  = sign_q;
      bad_d   = bad_q;
      err_d   = err_q;
      bin_d   = bin_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = {op_c.hundreds, op_c.tens, op_c.ones, MAG_W'(0)};
               sign_d  = op_c.sign;
               bad_d   = inv_c;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Rejected operands spend one cycle here without shifting so that
            // done lands two cycles after acceptance.
            if (bad_q) begin
               err_d   = 1'b1;
               bin_d   = '0;
               state_d = DONE;
            end else begin
               sr_d  = sr_adj_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(SHIFT_CNT - 1)) begin
                  state_d = NEG;
               end
            end
         end
         NEG: begin
            // Negating zero gives zero, so no negative-zero special case.
            bin_d   = sign_q ? (BIN_W'(0) - mag_ext_c) : mag_ext_c;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT) || (state_d == NEG);
      done_d = (state_d == DONE);
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign binary = bin_q;
   assign err    = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: arithmetic reference model compared
// every cycle, plus directed cases with hand-computed expectations.
module tb_bcd2bin_seq;

   logic        clk = 1'b0;
   logic        ar = 1'b1;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic [3:0]  hundreds = 4'd0;
   logic [3:0]  tens = 4'd0;
   logic [3:0]  ones = 4'd0;
   logic        busy, done, err;
   logic [10:0] binary;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd2bin_seq dut (
      .clk      (clk),
      .ar       (ar),
      .start    (start),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .sign     (sign),
      .busy     (busy),
      .done     (done),
      .binary   (binary),
      .err      (err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase counts cycles since acceptance (0 = idle).
   int          m_phase = 0;
   int          m_done_at = 12;
   logic [10:0] m_bin = 11'd0;
   logic        m_err = 1'b0;
   logic [10:0] m_pend = 11'd0;
   logic        m_pend_err = 1'b0;

   always @(posedge clk or negedge ar) begin
      if (!ar) begin
         m_phase = 0;
         m_bin   = 11'd0;
         m_err   = 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            int v;
            v = int'(hundreds) * 100 + int'(tens) * 10 + int'(ones);
            if (sign) v = -v;
            m_pend     = 11'(v);
            m_pend_err = 1'b0;
            m_done_at  = 12;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (hundreds > 4'd9 || tens > 4'd9 || ones > 4'd9) begin
               m_pend     = 11'd0;
               m_pend_err = 1'b1;
               m_done_at  = 2;
            end
`endif
            m_err   = 1'b0;
            m_phase = 1;
         end
      end else if (m_phase == m_done_at) begin
         m_phase = 0;
      end else begin
         m_phase++;
         if (m_phase == m_done_at) begin
            m_bin = m_pend;
            m_err = m_pend_err;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check("busy",   int'(busy),   int'(m_phase >= 1 && m_phase < m_done_at));
      check("done",   int'(done),   int'(m_phase != 0 && m_phase == m_done_at));
      check("binary", int'(binary), int'(m_bin));
      check("err",    int'(err),    int'(m_err));
      check("busy_done_excl", int'(busy & done), 0);
   end

   // Pulse start for one cycle, then count cycles until done (bounded).
   task automatic run(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                      input logic s, output int lat);
      @(negedge clk);
      hundreds = h; tens = t; ones = o; sign = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cyc;
      int dones;
      int first;

      #1 ar = 1'b0;
      @(negedge clk);
      check("rst_busy",   int'(busy),   0);
      check("rst_done",   int'(done),   0);
      check("rst_binary", int'(binary), 0);
      check("rst_err",    int'(err),    0);
      @(negedge clk);
      ar = 1'b1;
      repeat (2) @(negedge clk);

      // Largest positive value.
      run(4'd9, 4'd9, 4'd9, 1'b0, lat);
      check("lat_999", lat, 12);
      check("bin_999", int'(binary), 'h3E7);
      check("err_999", int'(err), 0);

      // Negative and negative-zero.
      run(4'd1, 4'd2, 4'd7, 1'b1, lat);
      check("lat_m127", lat, 12);
      check("bin_m127", int'(binary), 'h781);
      run(4'd0, 4'd0, 4'd0, 1'b1, lat);
      check("bin_m0", int'(binary), 0);
      run(4'd9, 4'd9, 4'd9, 1'b1, lat);
      check("bin_m999", int'(binary), 'h419);

      // Start re-pulsed during SHIFT and NEG with other digits.
      @(negedge clk);
      hundreds = 4'd3; tens = 4'd0; ones = 4'd8; sign = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; dones = 0; first = 0;
      repeat (20) begin
         if (done) begin
            dones++;
            if (first == 0) first = cyc;
         end
         if (cyc == 3 || cyc == 11) begin
            start = 1'b1; hundreds = 4'd7; tens = 4'd1; ones = 4'd4; sign = 1'b1;
         end else begin
            start = 1'b0;
            hundreds = 4'($urandom_range(9)); tens = 4'($urandom_range(9));
         end
         @(negedge clk);
         cyc++;
      end
      check("repulse_dones", dones, 1);
      check("repulse_lat", first, 12);
      check("repulse_bin", int'(binary), 308);

`ifdef BCD2BIN_DIGIT_CHECK_EN
      run(4'd0, 4'd10, 4'd5, 1'b0, lat);
      check("inv_lat", lat, 2);
      check("inv_err", int'(err), 1);
      check("inv_bin", int'(binary), 0);
      run(4'd0, 4'd0, 4'd5, 1'b0, lat);
      check("after_inv_err", int'(err), 0);
      check("after_inv_bin", int'(binary), 5);
`endif

      // Reset in the middle of a conversion.
      @(negedge clk);
      hundreds = 4'd7; tens = 4'd7; ones = 4'd7; sign = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 ar = 1'b0;
      #1;
      check("midrst_busy",   int'(busy),   0);
      check("midrst_done",   int'(done),   0);
      check("midrst_binary", int'(binary), 0);
      @(negedge clk);
      ar = 1'b1;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst_no_done", dones, 0);
      run(4'd4, 4'd5, 4'd6, 1'b0, lat);
      check("rst_restart_lat", lat, 12);
      check("rst_restart_bin", int'(binary), 456);

      // Random traffic, checked against the model every cycle.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         start    = ($urandom_range(3) == 0);
         hundreds = 4'($urandom_range(9));
         tens     = 4'($urandom_range(9));
         ones     = 4'($urandom_range(9));
         sign     = 1'($urandom_range(1));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (16) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
